sync_ram_ctrl: RTL and testbench

SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

---
 rtl/sync_ram_ctrl.sv | 118 +++++++++++
 tb/tb_sync_ram_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM controller with a self-zeroing INIT sequence.
// Requests complete in one cycle; out-of-range addresses get an error response.
module sync_ram_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clear,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              init_busy
);

    localparam int unsigned CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    logic                accept_c;
    logic                in_range_c;
    logic [CNT_W-1:0]    idx_c;

    // Extra compare bit keeps DEPTH == 2**ADDR_W from wrapping to zero
    assign in_range_c = ({1'b0, req_addr} < CMP_W'(DEPTH));
    assign idx_c      = req_addr[CNT_W-1:0];
    assign req_ready  = (state_q == ST_IDLE);
    assign init_busy  = (state_q == ST_INIT);
    assign accept_c   = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage is never reset; INIT zeroes one entry per cycle instead
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (accept_c && req_we && in_range_c) begin
            mem_q[idx_c] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= accept_c;
            if (accept_c) begin
                if (!in_range_c) begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b1;
                end else begin
                    resp_rdata_q <= req_we ? req_wdata : mem_q[idx_c];
                    resp_err_q   <= 1'b0;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed testbench for sync_ram_ctrl (DEPTH = 16, ADDR_W = 5, DATA_W = 8).
module tb_sync_ram_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              clear;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              init_busy;

    int total = 0;
    int bad   = 0;

    // Back-to-back vectors; expected = {resp_valid, resp_err, resp_rdata}
    localparam logic       B2B_WE  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [4:0] B2B_AD  [8] = '{5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd25, 5'd2, 5'd15};
    localparam logic [7:0] B2B_WD  [8] = '{8'h10, 8'h20, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'hF0};
    localparam logic [9:0] B2B_EXP [8] = '{10'h210, 10'h220, 10'h210, 10'h211,
                                          10'h211, 10'h300, 10'h220, 10'h2F0};

    sync_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .clear      (clear),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .init_busy  (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        clear     = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    // Counts sampled cycles with init_busy = 1; start covers samples already seen
    task automatic measure_init(input int start, output int n);
        n = start;
        while (init_busy === 1'b1 && n < 200) begin
            tick();
            if (init_busy === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({init_busy, req_ready, resp_valid, resp_err, resp_rdata} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b v=%b err=%b rd=%h want 1 0 0 0 00",
                     init_busy, req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst_n = 1'b1;
        measure_init(1, n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL reset_init_len: got %0d want 16", n);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_init_zero();
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, ADDR_W'(a), 8'h00);
            tick();
            total++;
            if ({resp_valid, resp_err, resp_rdata} !== 10'h200) begin
                bad++;
                $display("FAIL init_zero[%0d]: got v=%b err=%b rd=%h want 1 0 00",
                         a, resp_valid, resp_err, resp_rdata);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL init_zero_idle: got v=%b want 0", resp_valid);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd3, 8'hA5);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h2A5) begin
            bad++;
            $display("FAIL wr3_resp: got v=%b err=%b rd=%h want 1 0 a5", resp_valid, resp_err, resp_rdata);
        end
        drive(1'b0, 5'd3, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h2A5) begin
            bad++;
            $display("FAIL rd3_resp: got v=%b err=%b rd=%h want 1 0 a5", resp_valid, resp_err, resp_rdata);
        end
        idle_inputs();
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h0A5) begin
            bad++;
            $display("FAIL wr_rd_hold: got v=%b err=%b rd=%h want 0 0 a5", resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 5'd0, 8'h11);
        tick();
        drive(1'b0, 5'd20, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h300) begin
            bad++;
            $display("FAIL oor_rd20: got v=%b err=%b rd=%h want 1 1 00", resp_valid, resp_err, resp_rdata);
        end
        idle_inputs();
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h100) begin
            bad++;
            $display("FAIL oor_hold: got v=%b err=%b rd=%h want 0 1 00", resp_valid, resp_err, resp_rdata);
        end
        drive(1'b1, 5'd16, 8'h77);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h300) begin
            bad++;
            $display("FAIL oor_wr16: got v=%b err=%b rd=%h want 1 1 00", resp_valid, resp_err, resp_rdata);
        end
        drive(1'b0, 5'd0, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h211) begin
            bad++;
            $display("FAIL oor_rd0: got v=%b err=%b rd=%h want 1 0 11", resp_valid, resp_err, resp_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_clear();
        int n;
        drive(1'b1, 5'd7, 8'h3C);
        tick();
        drive(1'b0, 5'd7, 8'h00);
        clear = 1'b1;
        tick();
        total++;
        if ({init_busy, resp_valid, resp_err, resp_rdata} !== 11'h63C) begin
            bad++;
            $display("FAIL clear_rd7: got busy=%b v=%b err=%b rd=%h want 1 1 0 3c",
                     init_busy, resp_valid, resp_err, resp_rdata);
        end
        clear = 1'b0;
        drive(1'b1, 5'd5, 8'h99);
        tick();
        total++;
        if ({req_ready, resp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL clear_ignore: got rdy=%b v=%b want 0 0", req_ready, resp_valid);
        end
        idle_inputs();
        measure_init(2, n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL clear_init_len: got %0d want 16", n);
        end
        drive(1'b0, 5'd7, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h200) begin
            bad++;
            $display("FAIL clear_rd7_after: got v=%b err=%b rd=%h want 1 0 00", resp_valid, resp_err, resp_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_clear_mid_init();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        measure_init(1, n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL clear_mid_init_len: got %0d want 16", n);
        end
    endtask

    task automatic test_reset_mid_traffic();
        int n;
        drive(1'b1, 5'd8, 8'hC0);
        tick();
        drive(1'b1, 5'd9, 8'hC1);
        tick();
        drive(1'b1, 5'd10, 8'hC2);
        rst_n = 1'b0;
        #1;
        total++;
        if ({init_busy, req_ready, resp_valid, resp_err, resp_rdata} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL rst_mid_outputs: got busy=%b rdy=%b v=%b err=%b rd=%h want 1 0 0 0 00",
                     init_busy, req_ready, resp_valid, resp_err, resp_rdata);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_noresp: got v=%b want 0", resp_valid);
        end
        idle_inputs();
        rst_n = 1'b1;
        measure_init(1, n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL rst_mid_init_len: got %0d want 16", n);
        end
        drive(1'b0, 5'd8, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h200) begin
            bad++;
            $display("FAIL rst_mid_rd8: got v=%b err=%b rd=%h want 1 0 00", resp_valid, resp_err, resp_rdata);
        end
        drive(1'b0, 5'd9, 8'h00);
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h200) begin
            bad++;
            $display("FAIL rst_mid_rd9: got v=%b err=%b rd=%h want 1 0 00", resp_valid, resp_err, resp_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(B2B_WE[i], B2B_AD[i], B2B_WD[i]);
            tick();
            total++;
            if ({resp_valid, resp_err, resp_rdata} !== B2B_EXP[i]) begin
                bad++;
                $display("FAIL b2b[%0d]: got v=%b err=%b rd=%h want %h",
                         i, resp_valid, resp_err, resp_rdata, B2B_EXP[i]);
            end
        end
        idle_inputs();
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== 10'h0F0) begin
            bad++;
            $display("FAIL b2b_end: got v=%b err=%b rd=%h want 0 0 f0", resp_valid, resp_err, resp_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_init_zero();
        test_write_read();
        test_out_of_range();
        test_clear();
        test_clear_mid_init();
        test_reset_mid_traffic();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
